gemm_tile_sequencer: RTL and testbench
======================================

Name: gemm_tile_sequencer

Overview:
- Parametrised successor to the GEMM mode decoder.
- Accepts a GEMM command carrying K and N sizes and latches the systolic-array mode and input-feature/weight mux selects for the whole command.
- Splits K into SYS_ROWS-sized tiles and N into SYS_COLS-sized tiles, then issues one tile descriptor per valid/ready handshake to the datapath controller.
- Sits between the command front-end and the systolic-array load/compute controller.

Parameters:
- DIM_W, 8: width of the K/N size inputs and of the tile indices.
- SYS_ROWS, Config::SMALL_SYS_ROWS: tile height along K.
- SYS_COLS, Config::SMALL_SYS_COLS: tile width along N.
- LEN_W, $clog2(max(SYS_ROWS,SYS_COLS))+1: width of the tile length outputs.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_ksize  in  DIM_W  reduction dimension K
- cmd_nsize  in  DIM_W  output-column dimension N
- tile_valid  out  1  tile descriptor valid
- tile_ready  in  1  consumer accepts the descriptor
- tile_mode  out  2  gemm_mode_e for the command
- tile_if_mux_sel  out  1  input-feature mux select
- tile_w_mux_sel  out  1  weight mux select
- tile_k_idx  out  DIM_W  K tile index
- tile_n_idx  out  DIM_W  N tile index
- tile_k_len  out  LEN_W  valid rows in this tile
- tile_n_len  out  LEN_W  valid columns in this tile
- tile_last  out  1  final tile of the command
- busy  out  1  state is not IDLE
- done  out  1  one-cycle pulse at command completion

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high on rst.
- Reset: state=IDLE. All outputs are 0, including cmd_ready, while rst=1. cmd_ready rises in the first cycle after rst deasserts.
- FSM states: IDLE, DECODE, ISSUE, DONE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready, latch ksize/nsize and go to DECODE.
- DECODE (exactly 1 cycle):
  - tall = ksize<=SYS_ROWS; wide = nsize>SYS_COLS.
  - mode and selects:
    - !tall&&wide: mode 00, if=1, w=0.
    - !tall&&!wide: mode 01, if=1, w=0.
    - tall&&wide: mode 10, if=0, w=1.
    - tall&&!wide: mode 11, if=0, w=1.
  - k_tiles=ceil(ksize/SYS_ROWS); n_tiles=ceil(nsize/SYS_COLS). Use shifts when SYS_* is a power of two.
  - If ksize==0 or nsize==0, go to DONE. Otherwise clear k_idx/n_idx and go to ISSUE.
- ISSUE:
  - tile_valid=1.
  - Descriptor fields are registered and must hold stable while tile_valid&&!tile_ready.
  - k_len=min(SYS_ROWS, ksize-k_idx*SYS_ROWS); n_len is computed the same way against SYS_COLS.
  - Order: K inner, N outer. On a handshake k_idx increments; when k_idx==k_tiles-1, k_idx wraps to 0 and n_idx increments.
  - tile_last=1 when k_idx==k_tiles-1 && n_idx==n_tiles-1. The handshake on the last tile moves to DONE.
- DONE: done=1 for one cycle, then go to IDLE. cmd_ready is 0 in this cycle, so no back-to-back overlap.
- Latency: a command accepted in cycle T gives first tile_valid in T+2; done follows the last handshake by 1 cycle.
- tile_mode and the selects hold their command value from DECODE until the next command is accepted.
- cmd_valid in any non-IDLE state is ignored; the command is not lost because cmd_ready=0.
- Reset mid-operation: the sequencer abandons the command. The next cycle has tile_valid=0 and done=0, with no partial done pulse.
- Sizes at the maximum value 2^DIM_W-1 must not overflow. Remainder arithmetic uses DIM_W+1 bits.

Optional Feature:
- Macro: GEMM_TILE_SEQ_PERF_EN.
- Defined:
  - Adds output perf_stall_cnt [31:0], which counts cycles in ISSUE with tile_valid&&!tile_ready.
  - The counter clears on command accept, saturates at all-ones, and is 0 on reset.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Config package gains typedef enum logic[1:0] gemm_mode_e: MODE_WIDE=00, MODE_VERT=01, MODE_TALL_WIDE=10, MODE_TALL=11.
- SMALL_SYS_ROWS and SMALL_SYS_COLS stay in Config.
- One sub-module, gemm_tile_counter, instantiated twice (K and N). It holds the tile count, index and wrap, and computes the remainder length.

Test Plan (SYS 16x16):
- K=40,N=20, tile_ready=1 → mode 00, if=1, w=0; 6 tiles in order (k,n)=(0,0)(1,0)(2,0)(0,1)(1,1)(2,1); k_len 16,16,8; n_len 16 then 4; tile_last only on the 6th; done one cycle after it.
- K=16,N=16 → mode 11, if=0, w=1; a single tile with k_len=16, n_len=16, tile_last=1; first tile_valid exactly 2 cycles after accept.
- K=17,N=16 → mode 01; 2 tiles with k_len 16 then 1; K=16,N=17 → mode 10; 2 tiles with n_len 16 then 1.
- Backpressure: tile_ready=0 for 5 cycles on tile 2 → all descriptor fields stable; with GEMM_TILE_SEQ_PERF_EN defined, perf_stall_cnt=5.
- K=0,N=8 → no tile_valid; done pulses 2 cycles after accept; cmd_ready returns the cycle after done.
- rst asserted during ISSUE of tile 3 → next cycle tile_valid=0, done=0, cmd_ready=0 while rst=1, cmd_ready=1 after rst drops; a new command then runs normally.

Source files
------------

// File: rtl/gemm_tile_sequencer_pkg.sv
// Shared types and default array geometry for the GEMM tile sequencer.
package gemm_tile_sequencer_pkg;

  localparam int SMALL_SYS_ROWS = 16;
  localparam int SMALL_SYS_COLS = 16;

  typedef enum logic [1:0] {
    MODE_WIDE      = 2'b00,
    MODE_VERT      = 2'b01,
    MODE_TALL_WIDE = 2'b10,
    MODE_TALL      = 2'b11
  } gemm_mode_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_DECODE = 2'b01,
    S_ISSUE  = 2'b10,
    S_DONE   = 2'b11
  } seq_state_e;

endpackage

// File: rtl/gemm_tile_sequencer_if.sv
// Command and tile-descriptor channels of the GEMM tile sequencer.
interface gemm_tile_sequencer_if
  import gemm_tile_sequencer_pkg::*;
#(
  parameter int DIM_W = 8,
  parameter int LEN_W = 5
) ();

  logic             cmd_valid;
  logic             cmd_ready;
  logic [DIM_W-1:0] cmd_ksize;
  logic [DIM_W-1:0] cmd_nsize;
  logic             tile_valid;
  logic             tile_ready;
  gemm_mode_e       tile_mode;
  logic             tile_if_mux_sel;
  logic             tile_w_mux_sel;
  logic [DIM_W-1:0] tile_k_idx;
  logic [DIM_W-1:0] tile_n_idx;
  logic [LEN_W-1:0] tile_k_len;
  logic [LEN_W-1:0] tile_n_len;
  logic             tile_last;
  logic             busy;
  logic             done;

  // master is the sequencer; slave is the front-end plus datapath controller
  modport master (
    input  cmd_valid, cmd_ksize, cmd_nsize, tile_ready,
    output cmd_ready, tile_valid, tile_mode, tile_if_mux_sel, tile_w_mux_sel,
           tile_k_idx, tile_n_idx, tile_k_len, tile_n_len, tile_last, busy, done
  );

  modport slave (
    output cmd_valid, cmd_ksize, cmd_nsize, tile_ready,
    input  cmd_ready, tile_valid, tile_mode, tile_if_mux_sel, tile_w_mux_sel,
           tile_k_idx, tile_n_idx, tile_k_len, tile_n_len, tile_last, busy, done
  );

endinterface

// File: rtl/gemm_tile_sequencer_counter.sv
// One tiling dimension: tile count, current index with wrap, and remainder length.
module gemm_tile_counter #(
  parameter int DIM_W = 8,
  parameter int TILE  = 16,
  parameter int LEN_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIM_W-1:0] size,
  input  logic             clear,
  input  logic             step,
  output logic [DIM_W-1:0] idx,
  output logic [LEN_W-1:0] len,
  output logic             last
);

  localparam int CNT_W = DIM_W + 1;
  localparam logic [CNT_W-1:0] TILE_C  = CNT_W'(TILE);
  localparam logic [CNT_W-1:0] TILE_M1 = CNT_W'(TILE - 1);

  logic [CNT_W-1:0] tiles_q;
  logic [CNT_W-1:0] tiles_d;
  logic [CNT_W-1:0] base_q;
  logic [CNT_W-1:0] rem;

  // The extra bit keeps size + TILE-1 from wrapping at the maximum size
  generate
    if ((TILE & (TILE - 1)) == 0) begin : g_shift
      assign tiles_d = ({1'b0, size} + TILE_M1) >> $clog2(TILE);
    end else begin : g_div
      assign tiles_d = ({1'b0, size} + TILE_M1) / TILE_C;
    end
  endgenerate

  assign rem  = {1'b0, size} - base_q;
  assign len  = (rem > TILE_C) ? LEN_W'(TILE) : LEN_W'(rem);
  assign last = ({1'b0, idx} == (tiles_q - CNT_W'(1)));

  // base_q tracks idx*TILE incrementally so no multiplier is needed
  always_ff @(posedge clk) begin
    if (rst) begin
      tiles_q <= '0;
      idx     <= '0;
      base_q  <= '0;
    end else if (clear) begin
      tiles_q <= tiles_d;
      idx     <= '0;
      base_q  <= '0;
    end else if (step) begin
      if (last) begin
        idx    <= '0;
        base_q <= '0;
      end else begin
        idx    <= idx + DIM_W'(1);
        base_q <= base_q + TILE_C;
      end
    end
  end

endmodule

// File: rtl/gemm_tile_sequencer.sv
// Splits a GEMM command into K-inner/N-outer tile descriptors for the systolic array.
// Optional GEMM_TILE_SEQ_PERF_EN adds perf_stall_cnt (ISSUE cycles stalled by the consumer).
module gemm_tile_sequencer
  import gemm_tile_sequencer_pkg::*;
#(
  parameter int DIM_W    = 8,
  parameter int SYS_ROWS = SMALL_SYS_ROWS,
  parameter int SYS_COLS = SMALL_SYS_COLS,
  parameter int LEN_W    = $clog2((SYS_ROWS > SYS_COLS) ? SYS_ROWS : SYS_COLS) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  gemm_tile_sequencer_if.master bus
`ifdef GEMM_TILE_SEQ_PERF_EN
  ,
  output logic [31:0]           perf_stall_cnt
`endif
);

  seq_state_e       state_q;
  seq_state_e       state_d;
  logic [DIM_W-1:0] ksize_q;
  logic [DIM_W-1:0] nsize_q;
  gemm_mode_e       mode_q;
  logic             if_sel_q;
  logic             w_sel_q;
  logic             accept;
  logic             handshake;
  logic             zero_size;
  logic             tall;
  logic             wide;
  logic             k_last;
  logic             n_last;
  logic [DIM_W-1:0] k_idx;
  logic [DIM_W-1:0] n_idx;
  logic [LEN_W-1:0] k_len;
  logic [LEN_W-1:0] n_len;

  assign accept    = (state_q == S_IDLE) && bus.cmd_valid;
  assign handshake = (state_q == S_ISSUE) && bus.tile_ready;
  assign zero_size = (ksize_q == '0) || (nsize_q == '0);
  assign tall      = 32'(ksize_q) <= SYS_ROWS;
  assign wide      = 32'(nsize_q) > SYS_COLS;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (bus.cmd_valid) state_d = S_DECODE;
      S_DECODE: state_d = zero_size ? S_DONE : S_ISSUE;
      S_ISSUE:  if (bus.tile_ready && k_last && n_last) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Mode and selects persist past DONE so the datapath keeps its configuration
  always_ff @(posedge clk) begin
    if (rst) begin
      ksize_q  <= '0;
      nsize_q  <= '0;
      mode_q   <= MODE_WIDE;
      if_sel_q <= 1'b0;
      w_sel_q  <= 1'b0;
    end else begin
      if (accept) begin
        ksize_q <= bus.cmd_ksize;
        nsize_q <= bus.cmd_nsize;
      end
      if (state_q == S_DECODE) begin
        mode_q   <= gemm_mode_e'({tall, !wide});
        if_sel_q <= !tall;
        w_sel_q  <= tall;
      end
    end
  end

  gemm_tile_counter #(.DIM_W(DIM_W), .TILE(SYS_ROWS), .LEN_W(LEN_W)) u_k_cnt (
    .clk   (clk),
    .rst   (rst),
    .size  (ksize_q),
    .clear (state_q == S_DECODE),
    .step  (handshake),
    .idx   (k_idx),
    .len   (k_len),
    .last  (k_last)
  );

  gemm_tile_counter #(.DIM_W(DIM_W), .TILE(SYS_COLS), .LEN_W(LEN_W)) u_n_cnt (
    .clk   (clk),
    .rst   (rst),
    .size  (nsize_q),
    .clear (state_q == S_DECODE),
    .step  (handshake && k_last),
    .idx   (n_idx),
    .len   (n_len),
    .last  (n_last)
  );

  // Everything is forced low while rst is held, even before the reset edge lands
  always_comb begin
    bus.cmd_ready       = 1'b0;
    bus.tile_valid      = 1'b0;
    bus.busy            = 1'b0;
    bus.done            = 1'b0;
    bus.tile_mode       = MODE_WIDE;
    bus.tile_if_mux_sel = 1'b0;
    bus.tile_w_mux_sel  = 1'b0;
    bus.tile_k_idx      = '0;
    bus.tile_n_idx      = '0;
    bus.tile_k_len      = '0;
    bus.tile_n_len      = '0;
    bus.tile_last       = 1'b0;
    if (!rst) begin
      bus.cmd_ready       = (state_q == S_IDLE);
      bus.tile_valid      = (state_q == S_ISSUE);
      bus.busy            = (state_q != S_IDLE);
      bus.done            = (state_q == S_DONE);
      bus.tile_mode       = mode_q;
      bus.tile_if_mux_sel = if_sel_q;
      bus.tile_w_mux_sel  = w_sel_q;
      bus.tile_k_idx      = k_idx;
      bus.tile_n_idx      = n_idx;
      bus.tile_k_len      = k_len;
      bus.tile_n_len      = n_len;
      bus.tile_last       = (state_q == S_ISSUE) && k_last && n_last;
    end
  end

`ifdef GEMM_TILE_SEQ_PERF_EN
  always_ff @(posedge clk) begin
    if (rst || accept) begin
      perf_stall_cnt <= '0;
    end else if ((state_q == S_ISSUE) && !bus.tile_ready && (perf_stall_cnt != '1)) begin
      perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_gemm_tile_sequencer.sv
// Directed self-checking bench for gemm_tile_sequencer on a 16x16 array.
module tb_gemm_tile_sequencer;
  import gemm_tile_sequencer_pkg::*;

  localparam int DIM_W = 8;
  localparam int LEN_W = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   passes = 0;

  always #5 clk = ~clk;

  gemm_tile_sequencer_if #(.DIM_W(DIM_W), .LEN_W(LEN_W)) bus_if ();

`ifdef GEMM_TILE_SEQ_PERF_EN
  logic [31:0] perf_stall_cnt;
`endif

  gemm_tile_sequencer #(
    .DIM_W    (DIM_W),
    .SYS_ROWS (16),
    .SYS_COLS (16),
    .LEN_W    (LEN_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
`ifdef GEMM_TILE_SEQ_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed === expected) passes++;
    else $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
  endtask

  // All sampling and driving happens 1 time unit after the rising edge
  task automatic waitCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [DIM_W-1:0] k, input logic [DIM_W-1:0] n);
    for (int i = 0; i < 20 && !bus_if.cmd_ready; i++) waitCycle();
    checkOutput("cmd_ready_wait", 32'(bus_if.cmd_ready), 1);
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_ksize = k;
    bus_if.cmd_nsize = n;
    waitCycle();
    bus_if.cmd_valid = 1'b0;
  endtask

  task automatic waitTile();
    for (int i = 0; i < 40 && !bus_if.tile_valid; i++) waitCycle();
    checkOutput("tile_valid_wait", 32'(bus_if.tile_valid), 1);
  endtask

  task automatic checkTile(input int k, input int n, input int kl, input int nl, input int last);
    checkOutput("tile_k_idx",  32'(bus_if.tile_k_idx), k);
    checkOutput("tile_n_idx",  32'(bus_if.tile_n_idx), n);
    checkOutput("tile_k_len",  32'(bus_if.tile_k_len), kl);
    checkOutput("tile_n_len",  32'(bus_if.tile_n_len), nl);
    checkOutput("tile_last",   32'(bus_if.tile_last),  last);
  endtask

  task automatic consumeTile(input int k, input int n, input int kl, input int nl, input int last);
    waitTile();
    checkTile(k, n, kl, nl, last);
    waitCycle();
  endtask

  task automatic checkMode(input gemm_mode_e mode, input int if_sel, input int w_sel);
    checkOutput("tile_mode",       32'(bus_if.tile_mode),       32'(mode));
    checkOutput("tile_if_mux_sel", 32'(bus_if.tile_if_mux_sel), if_sel);
    checkOutput("tile_w_mux_sel",  32'(bus_if.tile_w_mux_sel),  w_sel);
  endtask

  task automatic expectDone();
    checkOutput("done_pulse",      32'(bus_if.done),       1);
    checkOutput("done_cmd_ready",  32'(bus_if.cmd_ready),  0);
    checkOutput("done_tile_valid", 32'(bus_if.tile_valid), 0);
    waitCycle();
    checkOutput("done_cleared",    32'(bus_if.done),      0);
    checkOutput("idle_cmd_ready",  32'(bus_if.cmd_ready), 1);
    checkOutput("idle_busy",       32'(bus_if.busy),      0);
  endtask

  initial begin
    bus_if.cmd_valid  = 1'b0;
    bus_if.cmd_ksize  = '0;
    bus_if.cmd_nsize  = '0;
    bus_if.tile_ready = 1'b1;

    waitCycle();
    waitCycle();
    checkOutput("rst_cmd_ready",  32'(bus_if.cmd_ready),  0);
    checkOutput("rst_tile_valid", 32'(bus_if.tile_valid), 0);
    checkOutput("rst_busy",       32'(bus_if.busy),       0);
    checkOutput("rst_done",       32'(bus_if.done),       0);
    checkOutput("rst_mode",       32'(bus_if.tile_mode),  0);
    rst = 1'b0;
    #1;
    checkOutput("post_rst_cmd_ready", 32'(bus_if.cmd_ready), 1);
    waitCycle();

    // K=40,N=20: 3x2 tiles, K inner
    applyStimulus(40, 20);
    checkOutput("decode_busy",      32'(bus_if.busy),      1);
    checkOutput("decode_cmd_ready", 32'(bus_if.cmd_ready), 0);
    waitTile();
    checkMode(MODE_WIDE, 1, 0);
    consumeTile(0, 0, 16, 16, 0);
    consumeTile(1, 0, 16, 16, 0);
    consumeTile(2, 0,  8, 16, 0);
    consumeTile(0, 1, 16,  4, 0);
    consumeTile(1, 1, 16,  4, 0);
    consumeTile(2, 1,  8,  4, 1);
    expectDone();
    checkOutput("mode_hold_idle", 32'(bus_if.tile_mode), 32'(MODE_WIDE));

    // K=16,N=16: single tile exactly two cycles after accept
    applyStimulus(16, 16);
    checkOutput("latency_decode", 32'(bus_if.tile_valid), 0);
    waitCycle();
    checkOutput("latency_issue",  32'(bus_if.tile_valid), 1);
    checkMode(MODE_TALL, 0, 1);
    consumeTile(0, 0, 16, 16, 1);
    expectDone();

    applyStimulus(17, 16);
    waitTile();
    checkMode(MODE_VERT, 1, 0);
    consumeTile(0, 0, 16, 16, 0);
    consumeTile(1, 0,  1, 16, 1);
    expectDone();

    applyStimulus(16, 17);
    waitTile();
    checkMode(MODE_TALL_WIDE, 0, 1);
    consumeTile(0, 0, 16, 16, 0);
    consumeTile(0, 1, 16,  1, 1);
    expectDone();

    // Backpressure: 5 stalled cycles on the second tile
    applyStimulus(48, 16);
    consumeTile(0, 0, 16, 16, 0);
    bus_if.tile_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      waitCycle();
      checkOutput("stall_valid", 32'(bus_if.tile_valid), 1);
      checkTile(1, 0, 16, 16, 0);
    end
`ifdef GEMM_TILE_SEQ_PERF_EN
    checkOutput("perf_stall_cnt", perf_stall_cnt, 5);
`endif
    bus_if.tile_ready = 1'b1;
    waitCycle();
    consumeTile(2, 0, 16, 16, 1);
    expectDone();
`ifdef GEMM_TILE_SEQ_PERF_EN
    checkOutput("perf_stall_hold", perf_stall_cnt, 5);
`endif

    // Zero K: no tiles, done two cycles after accept
    applyStimulus(0, 8);
    checkOutput("zero_decode_valid", 32'(bus_if.tile_valid), 0);
    checkOutput("zero_decode_done",  32'(bus_if.done),       0);
    checkOutput("zero_decode_busy",  32'(bus_if.busy),       1);
    waitCycle();
    checkOutput("zero_valid", 32'(bus_if.tile_valid), 0);
    expectDone();

    // Maximum K: 16 tiles, last one 15 rows
    applyStimulus(255, 1);
    waitTile();
    checkMode(MODE_VERT, 1, 0);
    for (int i = 0; i < 16; i++) consumeTile(i, 0, (i == 15) ? 15 : 16, 1, (i == 15) ? 1 : 0);
    expectDone();

    // Reset during the third tile abandons the command
    applyStimulus(40, 20);
    consumeTile(0, 0, 16, 16, 0);
    consumeTile(1, 0, 16, 16, 0);
    waitTile();
    checkTile(2, 0, 8, 16, 0);
    rst = 1'b1;
    waitCycle();
    checkOutput("midrst_tile_valid", 32'(bus_if.tile_valid), 0);
    checkOutput("midrst_done",       32'(bus_if.done),       0);
    checkOutput("midrst_cmd_ready",  32'(bus_if.cmd_ready),  0);
    checkOutput("midrst_busy",       32'(bus_if.busy),       0);
    rst = 1'b0;
    #1;
    checkOutput("midrst_release_ready", 32'(bus_if.cmd_ready), 1);
    checkOutput("midrst_release_done",  32'(bus_if.done),      0);
    waitCycle();
    applyStimulus(16, 16);
    waitTile();
    checkMode(MODE_TALL, 0, 1);
    consumeTile(0, 0, 16, 16, 1);
    expectDone();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
